draw_pixunpack: RTL and testbench
=================================

DRAW_PIXUNPACK -- requirements
Module: draw_pixunpack

Interface
REQ-001 SHALL have port CLK, input, 1 bit: single clock; all logic on its rising edge.
REQ-002 SHALL have port RST_X, input, 1 bit: reset, synchronous, active-low.
REQ-003 SHALL have port INIT, input, 1 bit: synchronous soft clear, same effect as reset.
REQ-004 SHALL have port START, input, 1 bit: one-cycle pulse; begins a transfer, ignored unless IDLE.
REQ-005 SHALL have port PIXCNT, input, 16 bits: pixel count, sampled on START.
REQ-006 SHALL have port FMT, input, 1 bit: pixel format, sampled on START; 0 = 16bpp (4 pixels/word), 1 = 32bpp (2 pixels/word).
REQ-007 SHALL have port FIRSTOFS, input, 2 bits: first pixel index in the first word, sampled on START; in 32bpp only bit0 is used.
REQ-008 SHALL have port SRC_DATA, input, 64 bits: word from the source buffer.
REQ-009 SHALL have port SRC_VALID, input, 1 bit: SRC_DATA valid; arrives exactly 1 cycle after BUF_RD.
REQ-010 SHALL have port SRC_EMPTY, input, 1 bit: source buffer empty.
REQ-011 SHALL have port BUF_RD, output, 1 bit: source buffer read strobe.
REQ-012 SHALL have port PIX_DATA, output, 32 bits: pixel; 16bpp pixels are zero-extended.
REQ-013 SHALL have port PIX_VALID, output, 1 bit: PIX_DATA valid.
REQ-014 SHALL have port PIX_READY, input, 1 bit: downstream accepts; a transfer occurs when PIX_VALID & PIX_READY.
REQ-015 SHALL have port PIX_LAST, output, 1 bit: marks the final pixel of the transfer.
REQ-016 SHALL have port BUSY, output, 1 bit: high from the cycle after an accepted START until DONE.
REQ-017 SHALL have port DONE, output, 1 bit: one-cycle completion pulse.
REQ-018 SHALL have port ERR, output, 1 bit: sticky protocol error.

Function
REQ-019 SHALL implement states IDLE, FETCH, WAIT, EMIT and FIN.
- IDLE -> FETCH on START with PIXCNT!=0.
- IDLE -> FIN on START with PIXCNT=0; no reads are issued.
- FETCH -> WAIT when BUF_RD is issued.
- WAIT -> EMIT on SRC_VALID.
- EMIT -> FETCH/WAIT after the last pixel of the word is accepted, if pixels remain.
- EMIT -> FIN when the remaining count reaches 0.
- FIN -> IDLE after 1 cycle, with DONE=1 in FIN.
REQ-020 SHALL assert BUF_RD only when SRC_EMPTY=0 and no read is outstanding, and either in FETCH or in the EMIT cycle that accepts the last pixel of the held word while remaining>1.
REQ-021 SHALL capture SRC_DATA into a 64-bit word register on SRC_VALID, and assert PIX_VALID from the following cycle.
- Best case: 1 bubble cycle per word.
REQ-022 SHALL order pixels little-endian.
- 16bpp: pixel k = word[16k+15:16k].
- 32bpp: pixel k = word[32k+31:32k].
REQ-023 SHALL start the first word at index FIRSTOFS; every later word starts at index 0.
REQ-024 SHALL decrement a 16-bit remaining counter on each accepted pixel, and assert PIX_LAST when remaining=1.
REQ-025 SHALL discard any unused pixels of the final word, and SHALL NOT read further words.
REQ-026 SHALL hold PIX_DATA/PIX_VALID/PIX_LAST stable while PIX_VALID=1 and PIX_READY=0.
REQ-027 SHALL remain in FETCH without reading while SRC_EMPTY=1.
REQ-028 SHALL set ERR on SRC_VALID with no read outstanding, and SHALL discard that data.
- ERR is cleared only by reset/INIT.
REQ-029 SHALL NOT assert BUF_RD in IDLE, WAIT or FIN.

Reset
REQ-030 SHALL, on RST_X=0 or INIT=1 at a clock edge, enter IDLE and zero all counters and the word register.
- Outputs after reset: BUF_RD=0, PIX_VALID=0, PIX_LAST=0, PIX_DATA=0, BUSY=0, DONE=0, ERR=0.
REQ-031 SHALL give RST_X/INIT priority over START and SRC_VALID in the same cycle.
- A read outstanding at INIT is dropped silently, without setting ERR.

Structure
REQ-032 SHALL take state encodings, FMT codes and pixels-per-word constants from the shared drawing package.
REQ-033 SHALL be a single module with no sub-modules; the pixel select is an inline mux.

Verification
REQ-034 SHALL verify 16bpp, PIXCNT=6, FIRSTOFS=0, buffer holds 64'h0004_0003_0002_0001, 64'h0008_0007_0006_0005, PIX_READY=1:
- pixels 1..6 emitted; PIX_LAST on 6; exactly 2 BUF_RD; DONE 1 cycle after the last pixel.
REQ-035 SHALL verify 32bpp, PIXCNT=3, FIRSTOFS=1, words 64'hBBBB_BBBB_AAAA_AAAA, 64'hDDDD_DDDD_CCCC_CCCC:
- output BBBBBBBB, CCCCCCCC, DDDDDDDD; PIX_LAST on DDDDDDDD.
REQ-036 SHALL verify PIX_READY toggled 1/0 every cycle during a 16bpp PIXCNT=8 transfer:
- data stable while stalled; no pixel lost or duplicated; 2 reads.
REQ-037 SHALL verify SRC_EMPTY=1 held 10 cycles after START:
- BUF_RD=0 and PIX_VALID=0 throughout; normal completion after EMPTY falls.
REQ-038 SHALL verify PIXCNT=0:
- DONE pulses 2 cycles after START; BUF_RD never asserted.
REQ-039 SHALL verify an unsolicited SRC_VALID in IDLE and INIT asserted mid-transfer:
- unsolicited SRC_VALID sets ERR=1;
- after INIT, all outputs are at reset values and ERR=0.

Source files
------------

// File: rtl/draw_pixunpack_pkg.sv
// Shared drawing package: FSM state encoding, pixel format codes and
// pixels-per-word constants used by the pixel unpacker.
package draw_pixunpack_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_EMIT  = 3'd3,
    ST_FIN   = 3'd4
  } state_t;

  localparam logic FMT_16BPP = 1'b0;
  localparam logic FMT_32BPP = 1'b1;

  localparam int PPW_16BPP = 4;
  localparam int PPW_32BPP = 2;

  // Index of the final pixel slot in a 64-bit word for the given format.
  function automatic logic [1:0] last_idx(input logic fmt);
    if (fmt == FMT_32BPP) begin
      return 2'(PPW_32BPP - 1);
    end
    return 2'(PPW_16BPP - 1);
  endfunction

endpackage

// File: rtl/draw_pixunpack.sv
// Pixel unpacker: reads 64-bit words from a source buffer and emits them
// as individual 16bpp (zero-extended) or 32bpp pixels, little-endian,
// starting at FIRSTOFS in the first word. One read is outstanding at most;
// the next read is launched while the last pixel of a word is accepted so a
// steady stream costs one bubble cycle per word.
//
// Handshake: a pixel transfers on a clock edge where PIX_VALID & PIX_READY.
// While PIX_VALID=1 and PIX_READY=0 the pixel outputs hold stable. Source
// data answers BUF_RD exactly one cycle later with SRC_VALID; SRC_VALID with
// no read outstanding is a protocol error (sticky ERR) and its data is dropped.
module draw_pixunpack
  import draw_pixunpack_pkg::*;
(
  input  logic        CLK,
  input  logic        RST_X,
  input  logic        INIT,
  input  logic        START,
  input  logic [15:0] PIXCNT,
  input  logic        FMT,
  input  logic [1:0]  FIRSTOFS,
  input  logic [63:0] SRC_DATA,
  input  logic        SRC_VALID,
  input  logic        SRC_EMPTY,
  output logic        BUF_RD,
  output logic [31:0] PIX_DATA,
  output logic        PIX_VALID,
  input  logic        PIX_READY,
  output logic        PIX_LAST,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR,
  output logic [2:0]  DBG_STATE
);

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_rem;
  logic        r_fmt;
  logic [1:0]  r_idx;
  logic [63:0] r_word;
  logic        r_pend;
  logic        r_err;

  logic        w_rst;
  logic        w_acc;
  logic        w_word_end;
  logic        w_cap;
  logic        w_rd;
  logic        w_start;
  logic [31:0] w_pix;

  // INIT behaves exactly like the hardware reset and wins over everything.
  assign w_rst      = !RST_X || INIT;
  assign w_start    = (r_state == ST_IDLE) && START;
  assign w_acc      = (r_state == ST_EMIT) && PIX_READY;
  assign w_word_end = (r_idx == last_idx(r_fmt));
  assign w_cap      = SRC_VALID && r_pend;

  // State register.
  always_ff @(posedge CLK) begin
    if (w_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and read-strobe decode; a read is only launched when the
  // buffer has data and nothing is already in flight.
  always_comb begin
    w_next = r_state;
    w_rd   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (START) begin
          w_next = (PIXCNT == 16'd0) ? ST_FIN : ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (!SRC_EMPTY && !r_pend) begin
          w_rd   = 1'b1;
          w_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (w_cap) begin
          w_next = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (w_acc) begin
          if (r_rem == 16'd1) begin
            w_next = ST_FIN;
          end else if (w_word_end) begin
            if (!SRC_EMPTY && !r_pend) begin
              w_rd   = 1'b1;
              w_next = ST_WAIT;
            end else begin
              w_next = ST_FETCH;
            end
          end
        end
      end
      ST_FIN: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Outstanding-read flag and sticky protocol error.
  always_ff @(posedge CLK) begin
    if (w_rst) begin
      r_pend <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      if (w_rd) begin
        r_pend <= 1'b1;
      end else if (SRC_VALID) begin
        r_pend <= 1'b0;
      end
      if (SRC_VALID && !r_pend) begin
        r_err <= 1'b1;
      end
    end
  end

  // Word register: only solicited data is captured.
  always_ff @(posedge CLK) begin
    if (w_rst) begin
      r_word <= 64'd0;
    end else if (w_cap) begin
      r_word <= SRC_DATA;
    end
  end

  // Transfer parameters, remaining count and pixel index within the word.
  always_ff @(posedge CLK) begin
    if (w_rst) begin
      r_rem <= 16'd0;
      r_fmt <= FMT_16BPP;
      r_idx <= 2'd0;
    end else if (w_start) begin
      r_rem <= PIXCNT;
      r_fmt <= FMT;
      r_idx <= (FMT == FMT_32BPP) ? {1'b0, FIRSTOFS[0]} : FIRSTOFS;
    end else if (w_acc) begin
      r_rem <= r_rem - 16'd1;
      r_idx <= w_word_end ? 2'd0 : r_idx + 2'd1;
    end
  end

  // Little-endian pixel select out of the held word.
  always_comb begin
    w_pix = 32'd0;
    if (r_fmt == FMT_32BPP) begin
      w_pix = r_idx[0] ? r_word[63:32] : r_word[31:0];
    end else begin
      case (r_idx)
        2'd0:    w_pix = {16'd0, r_word[15:0]};
        2'd1:    w_pix = {16'd0, r_word[31:16]};
        2'd2:    w_pix = {16'd0, r_word[47:32]};
        default: w_pix = {16'd0, r_word[63:48]};
      endcase
    end
  end

  assign BUF_RD    = w_rd;
  assign PIX_VALID = (r_state == ST_EMIT);
  assign PIX_DATA  = PIX_VALID ? w_pix : 32'd0;
  assign PIX_LAST  = PIX_VALID && (r_rem == 16'd1);
  assign BUSY      = (r_state != ST_IDLE);
  assign DONE      = (r_state == ST_FIN);
  assign ERR       = r_err;
  assign DBG_STATE = r_state;

endmodule

// File: tb/tb_draw_pixunpack.sv
// Directed bench for draw_pixunpack: a source-buffer responder answers each
// BUF_RD one cycle later from src_q, a monitor collects accepted pixels, and
// one task per scenario compares against hand-computed expectations.
module tb_draw_pixunpack;
  import draw_pixunpack_pkg::*;

  logic        CLK = 1'b0;
  logic        RST_X;
  logic        INIT;
  logic        START;
  logic [15:0] PIXCNT;
  logic        FMT;
  logic [1:0]  FIRSTOFS;
  logic [63:0] SRC_DATA = 64'd0;
  logic        SRC_VALID = 1'b0;
  logic        SRC_EMPTY;
  logic        BUF_RD;
  logic [31:0] PIX_DATA;
  logic        PIX_VALID;
  logic        PIX_READY = 1'b1;
  logic        PIX_LAST;
  logic        BUSY;
  logic        DONE;
  logic        ERR;
  logic [2:0]  DBG_STATE;

  int errors = 0;
  int checks = 0;

  logic [63:0] src_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  logic        last_q[$];

  int cyc = 0;
  int rd_count = 0;
  int served = 0;
  int inj_req = 0;
  int inj_done = 0;
  int rd_base = 0;
  int done_cnt = 0;
  int done_cyc = -1;
  int last_cyc = -1;
  int stall_bad = 0;
  int stall_seen = 0;
  bit ready_mode = 1'b0;
  bit prev_stall = 1'b0;
  logic [31:0] prev_data = 32'd0;
  logic        prev_last = 1'b0;

  draw_pixunpack dut (
    .CLK(CLK), .RST_X(RST_X), .INIT(INIT), .START(START), .PIXCNT(PIXCNT),
    .FMT(FMT), .FIRSTOFS(FIRSTOFS), .SRC_DATA(SRC_DATA), .SRC_VALID(SRC_VALID),
    .SRC_EMPTY(SRC_EMPTY), .BUF_RD(BUF_RD), .PIX_DATA(PIX_DATA),
    .PIX_VALID(PIX_VALID), .PIX_READY(PIX_READY), .PIX_LAST(PIX_LAST),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .DBG_STATE(DBG_STATE)
  );

  // Clock and cycle counter
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;

  // Source buffer: answers each read one cycle later, or injects stray data
  always @(posedge CLK) begin
    #1;
    if (served != rd_count) begin
      SRC_VALID = 1'b1;
      if (src_q.size() > 0) SRC_DATA = src_q.pop_front();
      else SRC_DATA = 64'd0;
      served++;
    end else if (inj_done != inj_req) begin
      SRC_VALID = 1'b1;
      SRC_DATA  = 64'hDEAD_BEEF_0BAD_F00D;
      inj_done++;
    end else begin
      SRC_VALID = 1'b0;
    end
  end

  // Downstream ready: constant 1 or toggling every cycle
  always @(posedge CLK) begin
    #1;
    if (ready_mode) PIX_READY = ~PIX_READY;
    else PIX_READY = 1'b1;
  end

  // Monitor, sampled mid-cycle
  always @(negedge CLK) begin
    if (BUF_RD && RST_X && !INIT) rd_count++;
    if (PIX_VALID && PIX_READY) begin
      got_q.push_back(PIX_DATA);
      last_q.push_back(PIX_LAST);
      if (PIX_LAST) last_cyc = cyc;
    end
    if (DONE) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (prev_stall && !(PIX_VALID && PIX_DATA == prev_data && PIX_LAST == prev_last))
      stall_bad++;
    prev_stall = PIX_VALID && !PIX_READY;
    prev_data  = PIX_DATA;
    prev_last  = PIX_LAST;
    if (prev_stall) stall_seen++;
  end

  // Driver tasks
  task automatic clear_sb();
    src_q.delete();
    exp_q.delete();
    got_q.delete();
    last_q.delete();
    done_cnt   = 0;
    done_cyc   = -1;
    last_cyc   = -1;
    stall_bad  = 0;
    stall_seen = 0;
    rd_base    = rd_count;
  endtask

  task automatic start_xfer(input logic [15:0] cnt, input logic fmt, input logic [1:0] ofs,
                            output int raise_cyc);
    @(posedge CLK);
    #1;
    START = 1'b1; PIXCNT = cnt; FMT = fmt; FIRSTOFS = ofs;
    raise_cyc = cyc;
    @(posedge CLK);
    #1;
    START = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge CLK);
      if (DONE) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_reset();
    RST_X = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    checks++;
    if ({BUF_RD, PIX_VALID, PIX_LAST, BUSY, DONE, ERR} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b want 000000", {BUF_RD, PIX_VALID, PIX_LAST, BUSY, DONE, ERR});
    end
    checks++;
    if (PIX_DATA !== 32'd0) begin
      errors++;
      $display("FAIL reset_data: got %h want 0", PIX_DATA);
    end
    checks++;
    if (DBG_STATE !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_state: got %0d want %0d", DBG_STATE, ST_IDLE);
    end
    @(posedge CLK);
    #1 RST_X = 1'b1;
  endtask

  task automatic test_16bpp();
    int rc;
    bit ok;
    clear_sb();
    src_q.push_back(64'h0004_0003_0002_0001);
    src_q.push_back(64'h0008_0007_0006_0005);
    for (int i = 1; i <= 6; i++) exp_q.push_back(32'(i));
    start_xfer(16'd6, FMT_16BPP, 2'd0, rc);
    checks++;
    if (BUSY !== 1'b1) begin
      errors++;
      $display("FAIL 16bpp_busy: got %b want 1", BUSY);
    end
    wait_done(200, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL 16bpp_done_timeout: got no DONE want DONE");
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL 16bpp_count: got %0d want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i] || last_q[i] !== (i == exp_q.size() - 1)) begin
        errors++;
        $display("FAIL 16bpp_pix%0d: got %h last=%b want %h last=%b", i, got_q[i], last_q[i],
                 exp_q[i], (i == exp_q.size() - 1));
      end
    end
    checks++;
    if (rd_count - rd_base != 2) begin
      errors++;
      $display("FAIL 16bpp_reads: got %0d want 2", rd_count - rd_base);
    end
    checks++;
    if (done_cyc - last_cyc != 1 || done_cnt != 1) begin
      errors++;
      $display("FAIL 16bpp_done_timing: got gap=%0d pulses=%0d want gap=1 pulses=1",
               done_cyc - last_cyc, done_cnt);
    end
  endtask

  task automatic test_32bpp();
    int rc;
    bit ok;
    clear_sb();
    src_q.push_back(64'hBBBB_BBBB_AAAA_AAAA);
    src_q.push_back(64'hDDDD_DDDD_CCCC_CCCC);
    exp_q.push_back(32'hBBBB_BBBB);
    exp_q.push_back(32'hCCCC_CCCC);
    exp_q.push_back(32'hDDDD_DDDD);
    start_xfer(16'd3, FMT_32BPP, 2'd1, rc);
    wait_done(200, ok);
    checks++;
    if (!ok || got_q.size() != 3) begin
      errors++;
      $display("FAIL 32bpp_count: got %0d done=%b want 3 done=1", got_q.size(), ok);
    end
    for (int i = 0; i < 3 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i] || last_q[i] !== (i == 2)) begin
        errors++;
        $display("FAIL 32bpp_pix%0d: got %h last=%b want %h last=%b", i, got_q[i], last_q[i],
                 exp_q[i], (i == 2));
      end
    end
  endtask

  task automatic test_stall();
    int rc;
    bit ok;
    clear_sb();
    src_q.push_back(64'h0004_0003_0002_0001);
    src_q.push_back(64'h0008_0007_0006_0005);
    for (int i = 1; i <= 8; i++) exp_q.push_back(32'(i));
    ready_mode = 1'b1;
    start_xfer(16'd8, FMT_16BPP, 2'd0, rc);
    wait_done(300, ok);
    ready_mode = 1'b0;
    checks++;
    if (!ok || got_q.size() != 8) begin
      errors++;
      $display("FAIL stall_count: got %0d done=%b want 8 done=1", got_q.size(), ok);
    end
    for (int i = 0; i < 8 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i] || last_q[i] !== (i == 7)) begin
        errors++;
        $display("FAIL stall_pix%0d: got %h last=%b want %h last=%b", i, got_q[i], last_q[i],
                 exp_q[i], (i == 7));
      end
    end
    checks++;
    if (stall_bad != 0 || stall_seen == 0) begin
      errors++;
      $display("FAIL stall_hold: got bad=%0d stalls=%0d want bad=0 stalls>0", stall_bad, stall_seen);
    end
    checks++;
    if (rd_count - rd_base != 2) begin
      errors++;
      $display("FAIL stall_reads: got %0d want 2", rd_count - rd_base);
    end
  endtask

  task automatic test_empty();
    int rc;
    int bad;
    bit ok;
    clear_sb();
    src_q.push_back(64'h4444_3333_2222_1111);
    exp_q.push_back(32'h0000_3333);
    exp_q.push_back(32'h0000_4444);
    SRC_EMPTY = 1'b1;
    start_xfer(16'd2, FMT_16BPP, 2'd2, rc);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (BUF_RD !== 1'b0 || PIX_VALID !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0 || DBG_STATE !== ST_FETCH) begin
      errors++;
      $display("FAIL empty_hold: got bad=%0d state=%0d want bad=0 state=%0d", bad, DBG_STATE, ST_FETCH);
    end
    @(posedge CLK);
    #1 SRC_EMPTY = 1'b0;
    wait_done(200, ok);
    checks++;
    if (!ok || got_q.size() != 2) begin
      errors++;
      $display("FAIL empty_count: got %0d done=%b want 2 done=1", got_q.size(), ok);
    end
    for (int i = 0; i < 2 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i] || last_q[i] !== (i == 1)) begin
        errors++;
        $display("FAIL empty_pix%0d: got %h last=%b want %h last=%b", i, got_q[i], last_q[i],
                 exp_q[i], (i == 1));
      end
    end
    // The final word ends exactly on the last pixel: no extra read.
    checks++;
    if (rd_count - rd_base != 1) begin
      errors++;
      $display("FAIL empty_reads: got %0d want 1", rd_count - rd_base);
    end
  endtask

  task automatic test_zero();
    int rc;
    bit ok;
    clear_sb();
    start_xfer(16'd0, FMT_16BPP, 2'd0, rc);
    wait_done(20, ok);
    // START raised in cycle rc; DONE is high during cycle rc+1, captured by
    // the second rising edge after START went high.
    checks++;
    if (!ok || done_cyc != rc + 1 || done_cnt != 1) begin
      errors++;
      $display("FAIL zero_done: got cyc=%0d pulses=%0d want cyc=%0d pulses=1", done_cyc, done_cnt, rc + 1);
    end
    checks++;
    if (rd_count - rd_base != 0 || got_q.size() != 0) begin
      errors++;
      $display("FAIL zero_reads: got reads=%0d pix=%0d want 0 0", rd_count - rd_base, got_q.size());
    end
  endtask

  task automatic test_err_init();
    int rc;
    bit hit;
    clear_sb();
    inj_req++;
    repeat (3) @(negedge CLK);
    checks++;
    if (ERR !== 1'b1 || DBG_STATE !== ST_IDLE || PIX_VALID !== 1'b0) begin
      errors++;
      $display("FAIL err_set: got err=%b state=%0d pv=%b want 1 %0d 0", ERR, DBG_STATE, PIX_VALID, ST_IDLE);
    end
    clear_sb();
    src_q.push_back(64'h0004_0003_0002_0001);
    src_q.push_back(64'h0008_0007_0006_0005);
    start_xfer(16'd8, FMT_16BPP, 2'd0, rc);
    hit = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge CLK);
      if (rd_count - rd_base >= 2) begin
        hit = 1'b1;
        break;
      end
    end
    // INIT lands in the same cycle the second word is returned.
    #1 INIT = 1'b1;
    @(posedge CLK);
    #1 INIT = 1'b0;
    @(negedge CLK);
    checks++;
    if (!hit || got_q.size() != 4) begin
      errors++;
      $display("FAIL init_pixels: got %0d reached=%b want 4 reached=1", got_q.size(), hit);
    end
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== 32'(i + 1)) begin
        errors++;
        $display("FAIL init_pix%0d: got %h want %h", i, got_q[i], 32'(i + 1));
      end
    end
    checks++;
    if ({BUF_RD, PIX_VALID, PIX_LAST, BUSY, DONE, ERR} !== 6'b0 || PIX_DATA !== 32'd0 ||
        DBG_STATE !== ST_IDLE) begin
      errors++;
      $display("FAIL init_outputs: got flags=%b data=%h state=%0d want 000000 0 %0d",
               {BUF_RD, PIX_VALID, PIX_LAST, BUSY, DONE, ERR}, PIX_DATA, DBG_STATE, ST_IDLE);
    end
    repeat (3) @(negedge CLK);
    checks++;
    if (ERR !== 1'b0 || BUF_RD !== 1'b0 || PIX_VALID !== 1'b0) begin
      errors++;
      $display("FAIL init_quiet: got err=%b rd=%b pv=%b want 0 0 0", ERR, BUF_RD, PIX_VALID);
    end
  endtask

  initial begin
    RST_X = 1'b0; INIT = 1'b0; START = 1'b0; PIXCNT = 16'd0; FMT = 1'b0;
    FIRSTOFS = 2'd0; SRC_EMPTY = 1'b0;
    test_reset();
    test_16bpp();
    test_32bpp();
    test_stall();
    test_empty();
    test_zero();
    test_err_init();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
